// File: rtl/idex_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : idex_stage_reg
// Purpose  : ID/EX pipeline register with load-use stall and bubble injection.
//            Optional WB->ID bypass of read data under `IDEX_WB_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module idex_stage_reg #(
  parameter int DATA_W   = 32,
  parameter int REG_W    = 5,
  parameter int ALUFUN_W = 6,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                Hold,
  input  logic                Flush_IDEX,
  input  logic                Valid_ID,
  input  logic [DATA_W-1:0]   PC_ID,
  input  logic [DATA_W-1:0]   Databus1_ID,
  input  logic [DATA_W-1:0]   Databus2_ID,
  input  logic [DATA_W-1:0]   Imm_ID,
  input  logic [REG_W-1:0]    Read_register1_ID,
  input  logic [REG_W-1:0]    Read_register2_ID,
  input  logic [REG_W-1:0]    Rd_ID,
  input  logic                Use_rt_ID,
  input  logic                RegWrite_ID,
  input  logic                MemRead_ID,
  input  logic                MemWrite_ID,
  input  logic                ALUSrc1_ID,
  input  logic                ALUSrc2_ID,
  input  logic [1:0]          MemtoReg_ID,
  input  logic [1:0]          RegDst_ID,
  input  logic [ALUFUN_W-1:0] ALUFun_ID,
  input  logic                RegWrite_MEMWB,
  input  logic [REG_W-1:0]    Write_Register_MEMWB,
  input  logic [DATA_W-1:0]   Databus3_WB,
  output logic [DATA_W-1:0]   PC_IDEX,
  output logic [DATA_W-1:0]   Databus1_IDEX,
  output logic [DATA_W-1:0]   Databus2_IDEX,
  output logic [DATA_W-1:0]   Imm_IDEX,
  output logic [REG_W-1:0]    Read_register1_IDEX,
  output logic [REG_W-1:0]    Read_register2_IDEX,
  output logic [REG_W-1:0]    Rd_IDEX,
  output logic                RegWrite_IDEX,
  output logic                MemRead_IDEX,
  output logic                MemWrite_IDEX,
  output logic                ALUSrc1_IDEX,
  output logic                ALUSrc2_IDEX,
  output logic [1:0]          MemtoReg_IDEX,
  output logic [1:0]          RegDst_IDEX,
  output logic [ALUFUN_W-1:0] ALUFun_IDEX,
  output logic                Valid_IDEX,
  output logic                Stall,
  output logic [CNT_W-1:0]    Bubble_count
);

  typedef struct packed {
    logic [DATA_W-1:0]   pc;
    logic [DATA_W-1:0]   db1;
    logic [DATA_W-1:0]   db2;
    logic [DATA_W-1:0]   imm;
    logic [REG_W-1:0]    rs;
    logic [REG_W-1:0]    rt;
    logic [REG_W-1:0]    rd;
    logic                regwrite;
    logic                memread;
    logic                memwrite;
    logic                alusrc1;
    logic                alusrc2;
    logic [1:0]          memtoreg;
    logic [1:0]          regdst;
    logic [ALUFUN_W-1:0] alufun;
    logic                valid;
  } idex_t;

  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  idex_t            stage_q, stage_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic             w_haz;
  logic             w_bubble;
  logic [DATA_W-1:0] w_db1_sel;
  logic [DATA_W-1:0] w_db2_sel;

`ifdef IDEX_WB_BYPASS_EN
  // Register file lacks write-before-read, so take the value WB is writing now.
  logic w_byp1, w_byp2;
  assign w_byp1 = RegWrite_MEMWB && (Write_Register_MEMWB != '0) &&
                  (Write_Register_MEMWB == Read_register1_ID);
  assign w_byp2 = RegWrite_MEMWB && (Write_Register_MEMWB != '0) &&
                  (Write_Register_MEMWB == Read_register2_ID);
  assign w_db1_sel = w_byp1 ? Databus3_WB : Databus1_ID;
  assign w_db2_sel = w_byp2 ? Databus3_WB : Databus2_ID;
`else
  logic unused_bypass;
  assign unused_bypass = &{1'b0, RegWrite_MEMWB, Write_Register_MEMWB, Databus3_WB};
  assign w_db1_sel = Databus1_ID;
  assign w_db2_sel = Databus2_ID;
`endif

  assign w_haz = stage_q.valid && stage_q.memread && (stage_q.rt != '0) &&
                 ((stage_q.rt == Read_register1_ID) ||
                  (Use_rt_ID && (stage_q.rt == Read_register2_ID)));
  assign Stall    = w_haz && !Flush_IDEX && Valid_ID;
  assign w_bubble = Flush_IDEX || Stall;

  always_comb begin
    stage_d      = stage_q;
    bubble_cnt_d = bubble_cnt_q;
    if (!Hold) begin
      if (w_bubble) begin
        // Zeroed register numbers keep the forwarding unit from matching.
        stage_d = '0;
        if (bubble_cnt_q != c_CNT_MAX) begin
          bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
      end else begin
        stage_d.pc       = PC_ID;
        stage_d.db1      = w_db1_sel;
        stage_d.db2      = w_db2_sel;
        stage_d.imm      = Imm_ID;
        stage_d.rs       = Read_register1_ID;
        stage_d.rt       = Read_register2_ID;
        stage_d.rd       = Rd_ID;
        stage_d.regwrite = RegWrite_ID & Valid_ID;
        stage_d.memread  = MemRead_ID  & Valid_ID;
        stage_d.memwrite = MemWrite_ID & Valid_ID;
        stage_d.alusrc1  = ALUSrc1_ID  & Valid_ID;
        stage_d.alusrc2  = ALUSrc2_ID  & Valid_ID;
        stage_d.memtoreg = MemtoReg_ID & {2{Valid_ID}};
        stage_d.regdst   = RegDst_ID   & {2{Valid_ID}};
        stage_d.alufun   = ALUFun_ID   & {ALUFUN_W{Valid_ID}};
        stage_d.valid    = Valid_ID;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_q      <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stage_q      <= stage_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign PC_IDEX             = stage_q.pc;
  assign Databus1_IDEX       = stage_q.db1;
  assign Databus2_IDEX       = stage_q.db2;
  assign Imm_IDEX            = stage_q.imm;
  assign Read_register1_IDEX = stage_q.rs;
  assign Read_register2_IDEX = stage_q.rt;
  assign Rd_IDEX             = stage_q.rd;
  assign RegWrite_IDEX       = stage_q.regwrite;
  assign MemRead_IDEX        = stage_q.memread;
  assign MemWrite_IDEX       = stage_q.memwrite;
  assign ALUSrc1_IDEX        = stage_q.alusrc1;
  assign ALUSrc2_IDEX        = stage_q.alusrc2;
  assign MemtoReg_IDEX       = stage_q.memtoreg;
  assign RegDst_IDEX         = stage_q.regdst;
  assign ALUFun_IDEX         = stage_q.alufun;
  assign Valid_IDEX          = stage_q.valid;
  assign Bubble_count        = bubble_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_idex_stage_reg.sv
`default_nettype none
// Directed bench for idex_stage_reg; narrow bubble counter exercises saturation.
module tb_idex_stage_reg;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int AW = 6;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic reset, Hold, Flush_IDEX, Valid_ID, Use_rt_ID;
  logic [DW-1:0] PC_ID, Databus1_ID, Databus2_ID, Imm_ID, Databus3_WB;
  logic [RW-1:0] Read_register1_ID, Read_register2_ID, Rd_ID, Write_Register_MEMWB;
  logic RegWrite_ID, MemRead_ID, MemWrite_ID, ALUSrc1_ID, ALUSrc2_ID, RegWrite_MEMWB;
  logic [1:0] MemtoReg_ID, RegDst_ID;
  logic [AW-1:0] ALUFun_ID;
  logic [DW-1:0] PC_IDEX, Databus1_IDEX, Databus2_IDEX, Imm_IDEX;
  logic [RW-1:0] Read_register1_IDEX, Read_register2_IDEX, Rd_IDEX;
  logic RegWrite_IDEX, MemRead_IDEX, MemWrite_IDEX, ALUSrc1_IDEX, ALUSrc2_IDEX;
  logic [1:0] MemtoReg_IDEX, RegDst_IDEX;
  logic [AW-1:0] ALUFun_IDEX;
  logic Valid_IDEX, Stall;
  logic [CW-1:0] Bubble_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  idex_stage_reg #(.DATA_W(DW), .REG_W(RW), .ALUFUN_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .Hold(Hold), .Flush_IDEX(Flush_IDEX), .Valid_ID(Valid_ID),
    .PC_ID(PC_ID), .Databus1_ID(Databus1_ID), .Databus2_ID(Databus2_ID), .Imm_ID(Imm_ID),
    .Read_register1_ID(Read_register1_ID), .Read_register2_ID(Read_register2_ID),
    .Rd_ID(Rd_ID), .Use_rt_ID(Use_rt_ID), .RegWrite_ID(RegWrite_ID),
    .MemRead_ID(MemRead_ID), .MemWrite_ID(MemWrite_ID), .ALUSrc1_ID(ALUSrc1_ID),
    .ALUSrc2_ID(ALUSrc2_ID), .MemtoReg_ID(MemtoReg_ID), .RegDst_ID(RegDst_ID),
    .ALUFun_ID(ALUFun_ID), .RegWrite_MEMWB(RegWrite_MEMWB),
    .Write_Register_MEMWB(Write_Register_MEMWB), .Databus3_WB(Databus3_WB),
    .PC_IDEX(PC_IDEX), .Databus1_IDEX(Databus1_IDEX), .Databus2_IDEX(Databus2_IDEX),
    .Imm_IDEX(Imm_IDEX), .Read_register1_IDEX(Read_register1_IDEX),
    .Read_register2_IDEX(Read_register2_IDEX), .Rd_IDEX(Rd_IDEX),
    .RegWrite_IDEX(RegWrite_IDEX), .MemRead_IDEX(MemRead_IDEX),
    .MemWrite_IDEX(MemWrite_IDEX), .ALUSrc1_IDEX(ALUSrc1_IDEX),
    .ALUSrc2_IDEX(ALUSrc2_IDEX), .MemtoReg_IDEX(MemtoReg_IDEX),
    .RegDst_IDEX(RegDst_IDEX), .ALUFun_IDEX(ALUFun_IDEX), .Valid_IDEX(Valid_IDEX),
    .Stall(Stall), .Bubble_count(Bubble_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one ID instruction; settles before returning.
  task automatic id(input logic v, input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                    input logic use_rt, input logic rw, input logic mr,
                    input logic [DW-1:0] pc);
    Valid_ID = v; Read_register1_ID = rs; Read_register2_ID = rt; Rd_ID = 5'd10;
    Use_rt_ID = use_rt; RegWrite_ID = rw; MemRead_ID = mr;
    MemtoReg_ID = mr ? 2'd1 : 2'd0; PC_ID = pc;
    Databus1_ID = 32'h1000 + 32'(rs); Databus2_ID = 32'h2000 + 32'(rt);
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; Hold = 1'b0; Flush_IDEX = 1'b0;
    Imm_ID = 32'h5; MemWrite_ID = 1'b0; ALUSrc1_ID = 1'b0; ALUSrc2_ID = 1'b1;
    RegDst_ID = 2'd1; ALUFun_ID = 6'h21;
    RegWrite_MEMWB = 1'b0; Write_Register_MEMWB = '0; Databus3_WB = '0;
    id(1'b1, 5'd4, 5'd8, 1'b0, 1'b1, 1'b0, 32'h100);
    tick(); tick();
    chk("reset_valid", 32'(Valid_IDEX), 32'd0);
    chk("reset_regwrite", 32'(RegWrite_IDEX), 32'd0);
    chk("reset_pc", PC_IDEX, 32'd0);
    chk("reset_cnt", 32'(Bubble_count), 32'd0);
    chk("reset_stall", 32'(Stall), 32'd0);

    // addi $8,$4,5
    reset = 1'b1;
    tick();
    chk("addi_regwrite", 32'(RegWrite_IDEX), 32'd1);
    chk("addi_rs", 32'(Read_register1_IDEX), 32'd4);
    chk("addi_pc", PC_IDEX, 32'h100);
    chk("addi_db1", Databus1_IDEX, 32'h1004);
    chk("addi_alufun", 32'(ALUFun_IDEX), 32'h21);

    // lw $9 then add $10,$9,$3
    id(1'b1, 5'd2, 5'd9, 1'b0, 1'b1, 1'b1, 32'h104);
    chk("lw_nostall", 32'(Stall), 32'd0);
    tick();
    chk("lw_memread", 32'(MemRead_IDEX), 32'd1);
    id(1'b1, 5'd9, 5'd3, 1'b1, 1'b1, 1'b0, 32'h108);
    chk("lu_stall", 32'(Stall), 32'd1);
    tick();
    chk("lu_bub_regwrite", 32'(RegWrite_IDEX), 32'd0);
    chk("lu_bub_valid", 32'(Valid_IDEX), 32'd0);
    chk("lu_bub_rt", 32'(Read_register2_IDEX), 32'd0);
    chk("lu_bub_cnt", 32'(Bubble_count), 32'd1);
    chk("lu_stall_drop", 32'(Stall), 32'd0);
    tick();
    chk("lu_add_rs", 32'(Read_register1_IDEX), 32'd9);
    chk("lu_add_valid", 32'(Valid_IDEX), 32'd1);
    chk("lu_add_pc", PC_IDEX, 32'h108);

    // rt not used as source
    id(1'b1, 5'd2, 5'd9, 1'b0, 1'b1, 1'b1, 32'h10C);
    tick();
    id(1'b1, 5'd4, 5'd9, 1'b0, 1'b1, 1'b0, 32'h110);
    chk("rt_unused_stall", 32'(Stall), 32'd0);
    Use_rt_ID = 1'b1; #1;
    chk("rt_used_stall", 32'(Stall), 32'd1);
    Use_rt_ID = 1'b0; #1;
    tick();
    chk("rt_unused_loaded", 32'(Valid_IDEX), 32'd1);
    chk("rt_unused_cnt", 32'(Bubble_count), 32'd1);
    // lw with rt=$0 followed by a $0 source
    id(1'b1, 5'd2, 5'd0, 1'b0, 1'b1, 1'b1, 32'h114);
    tick();
    id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 32'h118);
    chk("zero_reg_stall", 32'(Stall), 32'd0);
    tick();

    // Flush with a hazard present
    id(1'b1, 5'd2, 5'd9, 1'b0, 1'b1, 1'b1, 32'h11C);
    tick();
    id(1'b1, 5'd9, 5'd3, 1'b1, 1'b1, 1'b0, 32'h120);
    Flush_IDEX = 1'b1; #1;
    chk("flush_stall", 32'(Stall), 32'd0);
    tick();
    Flush_IDEX = 1'b0; #1;
    chk("flush_valid", 32'(Valid_IDEX), 32'd0);
    chk("flush_cnt", 32'(Bubble_count), 32'd2);
    tick();

    // Hold during a stall
    id(1'b1, 5'd2, 5'd9, 1'b0, 1'b1, 1'b1, 32'h124);
    tick();
    id(1'b1, 5'd9, 5'd3, 1'b1, 1'b1, 1'b0, 32'h128);
    Hold = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_stall", 32'(Stall), 32'd1);
      chk("hold_memread", 32'(MemRead_IDEX), 32'd1);
      chk("hold_pc", PC_IDEX, 32'h124);
      chk("hold_cnt", 32'(Bubble_count), 32'd2);
    end
    Hold = 1'b0; #1;
    tick();
    chk("hold_bub_valid", 32'(Valid_IDEX), 32'd0);
    chk("hold_bub_cnt", 32'(Bubble_count), 32'd3);
    chk("hold_stall_drop", 32'(Stall), 32'd0);
    tick();
    chk("hold_add_pc", PC_IDEX, 32'h128);

    // Killed ID instruction gates its control bits
    id(1'b0, 5'd6, 5'd7, 1'b1, 1'b1, 1'b1, 32'h12C);
    tick();
    chk("invalid_regwrite", 32'(RegWrite_IDEX), 32'd0);
    chk("invalid_memread", 32'(MemRead_IDEX), 32'd0);
    chk("invalid_valid", 32'(Valid_IDEX), 32'd0);

    // Counter saturates at 3 for a 2-bit width
    Flush_IDEX = 1'b1; #1;
    tick();
    Flush_IDEX = 1'b0; #1;
    chk("sat_cnt", 32'(Bubble_count), 32'd3);

    // WB bypass of stale read data
    id(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 1'b0, 32'h130);
    Databus1_ID = 32'h1;
    RegWrite_MEMWB = 1'b1; Write_Register_MEMWB = 5'd5; Databus3_WB = 32'hDEADBEEF; #1;
    tick();
`ifdef IDEX_WB_BYPASS_EN
    chk("bypass_db1", Databus1_IDEX, 32'hDEADBEEF);
`else
    chk("bypass_db1", Databus1_IDEX, 32'h1);
`endif
    chk("bypass_db2", Databus2_IDEX, 32'h2007);
    RegWrite_MEMWB = 1'b0;

    // Reset in the middle of a stall
    id(1'b1, 5'd2, 5'd9, 1'b0, 1'b1, 1'b1, 32'h134);
    tick();
    id(1'b1, 5'd9, 5'd3, 1'b1, 1'b1, 1'b0, 32'h138);
    chk("rst_pre_stall", 32'(Stall), 32'd1);
    reset = 1'b0; #1;
    chk("rst_mid_stall", 32'(Stall), 32'd0);
    chk("rst_mid_valid", 32'(Valid_IDEX), 32'd0);
    chk("rst_mid_memread", 32'(MemRead_IDEX), 32'd0);
    chk("rst_mid_cnt", 32'(Bubble_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
